// File: rtl/attack_sched.sv
// =============================================================================
// Module   : attack_sched
// Brief    : Round-robin scheduler sharing one attack-set unit between two requesters.
// Revision : 1.0
// =============================================================================
`default_nettype none

module attack_sched #(
   parameter int LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_a,
   input  logic [767:0] boards_a,
   input  logic         side_a,
   input  logic         req_b,
   input  logic [767:0] boards_b,
   input  logic         side_b,
   output logic [767:0] eng_boards,
   output logic         eng_is_white,
   input  logic [63:0]  eng_attack,
   output logic         done_a,
   output logic         done_b,
   output logic [63:0]  attack_out,
   output logic         king_hit,
   output logic         busy
);

   localparam logic [3:0] c_LATENCY = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   logic [3:0]   r_cnt;
   logic         r_owner_b;
   logic         r_prio_b;
   logic         r_done_a;
   logic         r_done_b;
   logic         r_busy;
   logic [63:0]  r_attack;
   logic         r_king_hit;
   logic [767:0] r_eng_boards;
   logic         r_eng_is_white;

   logic         w_any_req;
   logic         w_grant_b;
   logic [63:0]  w_opp_king;

   assign w_any_req  = req_a | req_b;
   // B wins when it is alone, or when both ask and A was served last.
   assign w_grant_b  = req_b & (~req_a | r_prio_b);
   assign w_opp_king = r_eng_is_white ? r_eng_boards[5*64 +: 64] : r_eng_boards[11*64 +: 64];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= 4'd0;
         r_owner_b      <= 1'b0;
         r_prio_b       <= 1'b0;
         r_done_a       <= 1'b0;
         r_done_b       <= 1'b0;
         r_busy         <= 1'b0;
         r_attack       <= 64'd0;
         r_king_hit     <= 1'b0;
         r_eng_boards   <= 768'd0;
         r_eng_is_white <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_eng_boards   <= w_grant_b ? boards_b : boards_a;
                  r_eng_is_white <= w_grant_b ? side_b : side_a;
                  r_owner_b      <= w_grant_b;
                  r_prio_b       <= ~w_grant_b;
                  r_cnt          <= c_LATENCY;
                  r_busy         <= 1'b1;
                  r_state        <= S_RUN;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_attack   <= eng_attack;
                  r_king_hit <= |(eng_attack & w_opp_king);
                  r_done_a   <= ~r_owner_b;
                  r_done_b   <= r_owner_b;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_done_a <= 1'b0;
               r_done_b <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_done_a <= 1'b0;
               r_done_b <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign eng_boards   = r_eng_boards;
   assign eng_is_white = r_eng_is_white;
   assign done_a       = r_done_a;
   assign done_b       = r_done_b;
   assign attack_out   = r_attack;
   assign king_hit     = r_king_hit;
   assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_attack_sched.sv
// =============================================================================
// Module   : tb_attack_sched
// Brief    : Self-checking bench for attack_sched against a timestamp-based job model.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_attack_sched;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_a, side_a, req_b, side_b;
   logic [767:0] boards_a, boards_b;
   logic [767:0] eng_boards;
   logic         eng_is_white;
   logic [63:0]  eng_attack;
   logic         done_a, done_b;
   logic [63:0]  attack_out;
   logic         king_hit;
   logic         busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   attack_sched #(.LATENCY(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_a        (req_a),
      .boards_a     (boards_a),
      .side_a       (side_a),
      .req_b        (req_b),
      .boards_b     (boards_b),
      .side_b       (side_b),
      .eng_boards   (eng_boards),
      .eng_is_white (eng_is_white),
      .eng_attack   (eng_attack),
      .done_a       (done_a),
      .done_b       (done_b),
      .attack_out   (attack_out),
      .king_hit     (king_hit),
      .busy         (busy)
   );

   // Model: a job is described by its grant edge number; everything else follows by arithmetic.
   int           m_cyc;
   logic         m_jv;
   int           m_t0;
   logic         m_own;
   logic         m_last;
   logic [767:0] m_boards;
   logic         m_side;
   logic [63:0]  m_att;
   logic         m_kh;

   function automatic logic [63:0] opp_king(input logic [767:0] b, input logic s);
      return s ? b[5*64 +: 64] : b[11*64 +: 64];
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_jv = 1'b0; m_t0 = 0; m_own = 1'b0; m_last = 1'b1;
      m_boards = '0; m_side = 1'b0; m_att = '0; m_kh = 1'b0;
   endtask

   task automatic model_step();
      int e;
      logic own;
      e = m_cyc + 1;
      if (m_jv && e == m_t0 + LAT) begin
         m_att = eng_attack;
         m_kh  = |(eng_attack & opp_king(m_boards, m_side));
      end
      if ((!m_jv || e >= m_t0 + LAT + 2) && (req_a || req_b)) begin
         own      = (req_a && req_b) ? ~m_last : req_b;
         m_last   = own;
         m_jv     = 1'b1;
         m_t0     = e;
         m_own    = own;
         m_boards = own ? boards_b : boards_a;
         m_side   = own ? side_b : side_a;
      end
      m_cyc = e;
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0b exp=%0b", name, got, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic chk768(input string name, input logic [767:0] got, input logic [767:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic in_job, fin;
      in_job = m_jv && (m_cyc >= m_t0) && (m_cyc <= m_t0 + LAT);
      fin    = m_jv && (m_cyc == m_t0 + LAT);
      chk1  ("busy",         busy,         in_job);
      chk1  ("done_a",       done_a,       fin && !m_own);
      chk1  ("done_b",       done_b,       fin && m_own);
      chk64 ("attack_out",   attack_out,   m_att);
      chk1  ("king_hit",     king_hit,     m_kh);
      chk768("eng_boards",   eng_boards,   m_jv ? m_boards : 768'd0);
      chk1  ("eng_is_white", eng_is_white, m_jv ? m_side : 1'b0);
   endtask

   // Inputs are set at a falling edge; the model consumes them for the coming rising edge.
   task automatic advance();
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic check_reset_values(input string tag);
      chk1  ({tag, "_busy"},   busy,         1'b0);
      chk1  ({tag, "_done_a"}, done_a,       1'b0);
      chk1  ({tag, "_done_b"}, done_b,       1'b0);
      chk64 ({tag, "_att"},    attack_out,   64'd0);
      chk1  ({tag, "_kh"},     king_hit,     1'b0);
      chk768({tag, "_engb"},   eng_boards,   768'd0);
      chk1  ({tag, "_engw"},   eng_is_white, 1'b0);
   endtask

   task automatic reset_pulse();
      req_a = 1'b0;
      req_b = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_boards(output logic [767:0] b);
      for (int i = 0; i < 24; i++) b[i*32 +: 32] = $urandom;
      b[5*64 +: 64]  = 64'd1 << $urandom_range(0, 63);
      b[11*64 +: 64] = 64'd1 << $urandom_range(0, 63);
   endtask

   task automatic gen_attack();
      logic [63:0] r;
      r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) r = r | opp_king(eng_boards, eng_is_white);
      eng_attack = r;
   endtask

   task automatic run_job(input logic is_b, input logic side, input logic [767:0] b,
                          input logic [63:0] att, output logic seen);
      seen = 1'b0;
      if (is_b) begin
         req_b = 1'b1; side_b = side; boards_b = b; req_a = 1'b0;
      end else begin
         req_a = 1'b1; side_a = side; boards_a = b; req_b = 1'b0;
      end
      eng_attack = att;
      advance();
      req_a = 1'b0;
      req_b = 1'b0;
      for (int i = 0; i < LAT + 4 && !seen; i++) begin
         advance();
         if (is_b ? done_b : done_a) seen = 1'b1;
      end
      chk1("job_done_seen", seen, 1'b1);
   endtask

   initial begin
      logic [767:0] b;
      logic         seen;
      int           busy_cnt;
      int           ndone;
      logic [63:0]  seq;

      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; side_a = 1'b0; side_b = 1'b0;
      boards_a = '0; boards_b = '0; eng_attack = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      advance();

      // Single A job, black king at bit 20, requester drops after grant.
      b = '0;
      b[5*64 + 20] = 1'b1;
      req_a = 1'b1; side_a = 1'b1; boards_a = b;
      eng_attack = 64'h0000_0000_0010_0000;
      advance();
      chk1  ("A_busy_at_grant", busy, 1'b1);
      chk768("A_eng_boards", eng_boards, b);
      req_a = 1'b0;
      boards_a = ~b;
      side_a = 1'b0;
      busy_cnt = 1;
      for (int i = 0; i < LAT; i++) begin
         advance();
         if (busy) busy_cnt++;
      end
      chk1 ("A_done", done_a, 1'b1);
      chk64("A_attack_out", attack_out, 64'h0000_0000_0010_0000);
      chk1 ("A_king_hit", king_hit, 1'b1);
      chk1 ("A_eng_side_held", eng_is_white, 1'b1);
      advance();
      chk1 ("A_done_one_cycle", done_a, 1'b0);
      chk64("A_busy_cycles", 64'(busy_cnt), 64'(LAT + 1));
      advance();
      chk1 ("A_no_second_job", busy, 1'b0);

      // B jobs against the white king at bit 4: first misses, second hits.
      b = '0;
      b[11*64 + 4] = 1'b1;
      run_job(1'b1, 1'b0, b, 64'h0000_0000_0000_0008, seen);
      chk1 ("B_miss_kh", king_hit, 1'b0);
      chk64("B_miss_att", attack_out, 64'h8);
      advance();
      run_job(1'b1, 1'b0, b, 64'h0000_0000_0000_0010, seen);
      chk1 ("B_hit_kh", king_hit, 1'b1);
      advance();

      // Both requesters held high: grants must alternate starting with A.
      ndone = 0;
      seq = '0;
      req_a = 1'b1; req_b = 1'b1;
      for (int i = 0; i < 4 * (LAT + 2); i++) begin
         rand_boards(boards_a);
         rand_boards(boards_b);
         side_a = 1'($urandom_range(0, 1));
         side_b = 1'($urandom_range(0, 1));
         gen_attack();
         advance();
         if (done_a || done_b) begin
            ndone++;
            seq = (seq << 1) | {63'd0, done_b};
         end
      end
      chk64("alt_count", 64'(ndone), 64'd4);
      chk64("alt_order", seq, 64'h5);
      req_a = 1'b0; req_b = 1'b0;
      repeat (LAT + 2) advance();

      // Reset in the middle of a job, then a normal job afterwards.
      rand_boards(b);
      req_a = 1'b1; boards_a = b; side_a = 1'b1;
      advance();
      req_a = 1'b0;
      repeat (2) advance();
      chk1("mid_run_busy", busy, 1'b1);
      reset_pulse();
      advance();
      chk1("post_rst_idle", busy, 1'b0);
      rand_boards(b);
      run_job(1'b0, 1'b0, b, 64'hFFFF_0000_FFFF_0000, seen);
      chk64("post_rst_att", attack_out, 64'hFFFF_0000_FFFF_0000);
      advance();

      // Random traffic with occasional asynchronous resets.
      for (int c = 0; c < 1500; c++) begin
         req_a  = ($urandom_range(0, 3) != 0);
         req_b  = ($urandom_range(0, 3) != 0);
         side_a = 1'($urandom_range(0, 1));
         side_b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) rand_boards(boards_a);
         if ($urandom_range(0, 1) == 0) rand_boards(boards_b);
         gen_attack();
         if ($urandom_range(0, 199) == 0) reset_pulse();
         else advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/attack_sched.md
ATTACK_SCHED -- requirements
Module: attack_sched

Interface
REQ-001 Parameter: LATENCY, default 1, meaning cycles the shared attack-set unit needs from a stable input to a valid output; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_a  input  1  requester A (move generator) level request.
REQ-005 boards_a  input  768  requester A 12x64 piece bitboards; pieces 0..5 black, 6..11 white, piece p at bits [p*64 +: 64], king is p=5 / p=11.
REQ-006 side_a  input  1  requester A side to evaluate; 1 = white attacks.
REQ-007 req_b, boards_b, side_b  input  1/768/1  requester B (legality checker), same meaning as A.
REQ-008 eng_boards  output  768  registered bitboards driven to the shared attack-set unit.
REQ-009 eng_is_white  output  1  registered side driven to the shared attack-set unit.
REQ-010 eng_attack  input  64  attack set returned by the shared unit.
REQ-011 done_a, done_b  output  1  one-cycle completion pulse per requester.
REQ-012 attack_out  output  64  registered attack set of the last completed job.
REQ-013 king_hit  output  1  registered; 1 when attack_out intersects the opposing king bitboard of that job.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, RUN, DONE; exactly one job in flight.
REQ-016 IDLE: if any req high at an edge, grant one requester, load eng_boards/eng_is_white from its boards/side, record owner, load counter with LATENCY, go RUN; else stay IDLE.
REQ-017 Arbitration round-robin: requester not granted last wins when both request; after reset A has priority.
REQ-018 RUN: counter decrements each edge; at the edge where counter equals 1, capture eng_attack into attack_out, compute king_hit, go DONE.
REQ-019 king_hit source: job side 1 -> black king (piece 5); side 0 -> white king (piece 11), taken from the captured eng_boards, not the live requester inputs.
REQ-020 DONE: assert done of owner only, for exactly one cycle; next edge returns to IDLE.
REQ-021 Latency: req sampled at edge E0 -> done high during cycle after edge E0+LATENCY; throughput one job per LATENCY+2 cycles.
REQ-022 eng_boards/eng_is_white stay constant from grant until leaving DONE; they change only on a new grant.
REQ-023 Inputs captured at grant; changes to boards/side/req after grant do not affect the job; done still pulses even if req dropped.
REQ-024 req still high in IDLE after its done counts as a new request and is re-arbitrated under REQ-017.
REQ-025 attack_out and king_hit hold their values until the next job's capture.
REQ-026 done_a and done_b never high in the same cycle.

Reset
REQ-027 rst_n low forces immediately: state IDLE, counter 0, done_a=done_b=0, busy=0, attack_out=0, king_hit=0, eng_boards=0, eng_is_white=0, round-robin pointer favouring A.
REQ-028 Reset mid-job aborts it with no done pulse; first edge after rst_n rises behaves as IDLE.

Verification
REQ-029 Single A job, LATENCY=1: req_a at E0, side_a=1, eng_attack model returns 64'h0000_0000_0010_0000 with black king at bit 20 -> done_a high cycle after E1, attack_out matches, king_hit=1, busy high 2 cycles.
REQ-030 Simultaneous req_a and req_b held high after reset -> grants alternate A,B,A,B; done pulses alternate, never overlap.
REQ-031 LATENCY=4, boards_a changed every cycle after grant -> eng_boards constant, done_a at E0+4 follow-on cycle, result from boards captured at E0.
REQ-032 side_b=0, attack set misses white king at bit 4 -> king_hit=0; next job hitting the king -> king_hit=1 only after that capture.
REQ-033 rst_n pulsed low while in RUN -> all outputs reach REQ-027 values asynchronously, no done pulse, new request after release serviced normally.
REQ-034 req_a dropped one cycle after grant -> done_a still pulses once; no second job started.
